// File: rtl/rx_seq_checker.sv
// Incrementing-byte stream checker for a UART receive path.
// Hunts, confirms and locks onto a +1 mod 256 sequence.
module rx_seq_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_Rx_DV,
  input  logic [7:0]       i_Rx_Byte,
  input  logic             i_Clear,
  output logic             o_Locked,
  output logic [7:0]       o_Expected,
  output logic [CNT_W-1:0] o_Good_Count,
  output logic [CNT_W-1:0] o_Err_Count,
  output logic             o_Err_Pulse,
  output logic [7:0]       o_Last_Bad
);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);

  state_t     state;
  logic [3:0] streak;
  logic [3:0] miss;
  logic       match;
  logic [7:0] nxt;
  logic [3:0] streak_inc;
  logic [3:0] miss_inc;

  // Match against the current expectation; next expectation resyncs to the byte.
  always_comb begin
    match      = (i_Rx_Byte == o_Expected);
    nxt        = i_Rx_Byte + 8'd1;
    streak_inc = streak + 4'd1;
    miss_inc   = miss + 4'd1;
  end

  // Lock FSM with registered outputs, saturating counters and clear priority.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state        <= HUNT;
      streak       <= '0;
      miss         <= '0;
      o_Locked     <= 1'b0;
      o_Expected   <= 8'h00;
      o_Good_Count <= '0;
      o_Err_Count  <= '0;
      o_Err_Pulse  <= 1'b0;
      o_Last_Bad   <= 8'h00;
    end else begin
      o_Err_Pulse <= 1'b0;
      if (i_Clear) begin
        state        <= HUNT;
        streak       <= '0;
        miss         <= '0;
        o_Locked     <= 1'b0;
        o_Expected   <= 8'h00;
        o_Good_Count <= '0;
        o_Err_Count  <= '0;
        o_Last_Bad   <= 8'h00;
      end else if (i_Rx_DV) begin
        o_Expected <= nxt;
        unique case (state)
          HUNT: begin
            streak <= 4'd1;
            state  <= CONFIRM;
          end
          CONFIRM: begin
            if (match) begin
              streak <= streak_inc;
              if (streak_inc == LOCK_N) begin
                state    <= LOCKED;
                o_Locked <= 1'b1;
                miss     <= '0;
              end
            end else begin
              streak <= 4'd1;
            end
          end
          LOCKED: begin
            if (match) begin
              miss <= '0;
              if (o_Good_Count != '1)
                o_Good_Count <= o_Good_Count + 1'b1;
            end else begin
              o_Err_Pulse <= 1'b1;
              o_Last_Bad  <= i_Rx_Byte;
              miss        <= miss_inc;
              if (o_Err_Count != '1)
                o_Err_Count <= o_Err_Count + 1'b1;
              if (miss_inc == LOSS_N) begin
                state    <= HUNT;
                o_Locked <= 1'b0;
                streak   <= '0;
                miss     <= '0;
              end
            end
          end
          default: begin
            state    <= HUNT;
            o_Locked <= 1'b0;
            streak   <= '0;
            miss     <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_seq_checker.sv
// Directed self-checking bench for rx_seq_checker.
// Default instance plus a narrow-counter, high-loss instance.
module tb_rx_seq_checker;

  logic       clk;
  logic       rst_n;
  logic       dv;
  logic [7:0] rx_byte;
  logic       clr;

  logic        locked;
  logic [7:0]  expct;
  logic [15:0] good;
  logic [15:0] err;
  logic        pulse;
  logic [7:0]  last_bad;

  logic       s_locked;
  logic [7:0] s_expct;
  logic [3:0] s_good;
  logic [3:0] s_err;
  logic       s_pulse;
  logic [7:0] s_last_bad;

  int n_chk;
  int n_pass;

  rx_seq_checker dut (
    .i_Clk        (clk),
    .i_Rst_n      (rst_n),
    .i_Rx_DV      (dv),
    .i_Rx_Byte    (rx_byte),
    .i_Clear      (clr),
    .o_Locked     (locked),
    .o_Expected   (expct),
    .o_Good_Count (good),
    .o_Err_Count  (err),
    .o_Err_Pulse  (pulse),
    .o_Last_Bad   (last_bad)
  );

  rx_seq_checker #(
    .LOCK_COUNT (4),
    .LOSS_COUNT (15),
    .CNT_W      (4)
  ) dut_s (
    .i_Clk        (clk),
    .i_Rst_n      (rst_n),
    .i_Rx_DV      (dv),
    .i_Rx_Byte    (rx_byte),
    .i_Clear      (clr),
    .o_Locked     (s_locked),
    .o_Expected   (s_expct),
    .o_Good_Count (s_good),
    .o_Err_Count  (s_err),
    .o_Err_Pulse  (s_pulse),
    .o_Last_Bad   (s_last_bad)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic send(input logic [7:0] b);
    dv      = 1'b1;
    rx_byte = b;
    @(posedge clk);
    #1;
    dv      = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  logic [7:0] e;
  logic [7:0] b;

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    dv      = 1'b0;
    rx_byte = 8'h00;
    clr     = 1'b0;
    idle(2);

    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_exp", {24'd0, expct}, 32'h00);
    chk("rst_good", {16'd0, good}, 32'd0);
    chk("rst_err", {16'd0, err}, 32'd0);
    chk("rst_pulse", {31'd0, pulse}, 32'd0);
    chk("rst_lastbad", {24'd0, last_bad}, 32'd0);

    rst_n = 1'b1;
    idle(1);

    // Lock onto 10..13
    send(8'h10); send(8'h11); send(8'h12);
    chk("lock_pre", {31'd0, locked}, 32'd0);
    send(8'h13);
    chk("lock_on", {31'd0, locked}, 32'd1);
    chk("lock_exp", {24'd0, expct}, 32'h14);
    chk("lock_good", {16'd0, good}, 32'd0);
    chk("lock_err", {16'd0, err}, 32'd0);
    idle(3);
    chk("idle_exp", {24'd0, expct}, 32'h14);
    chk("idle_lock", {31'd0, locked}, 32'd1);

    // Wrap through FF -> 00
    do_clear();
    send(8'hFA); send(8'hFB); send(8'hFC); send(8'hFD);
    chk("wrap_lock", {31'd0, locked}, 32'd1);
    chk("wrap_exp0", {24'd0, expct}, 32'hFE);
    send(8'hFE); send(8'hFF); send(8'h00); send(8'h01);
    chk("wrap_good", {16'd0, good}, 32'd4);
    chk("wrap_err", {16'd0, err}, 32'd0);
    chk("wrap_exp", {24'd0, expct}, 32'h02);

    // Single corruption
    do_clear();
    send(8'h1C); send(8'h1D); send(8'h1E); send(8'h1F);
    chk("cor_exp0", {24'd0, expct}, 32'h20);
    send(8'h24);
    chk("cor_pulse", {31'd0, pulse}, 32'd1);
    chk("cor_err", {16'd0, err}, 32'd1);
    chk("cor_lastbad", {24'd0, last_bad}, 32'h24);
    chk("cor_locked", {31'd0, locked}, 32'd1);
    idle(1);
    chk("cor_pulse_off", {31'd0, pulse}, 32'd0);
    send(8'h25);
    chk("cor_good", {16'd0, good}, 32'd1);
    chk("cor_err2", {16'd0, err}, 32'd1);
    chk("cor_pulse_m", {31'd0, pulse}, 32'd0);
    chk("cor_locked2", {31'd0, locked}, 32'd1);

    // Loss of lock after three misses
    send(8'h50); send(8'h90);
    chk("loss_hold", {31'd0, locked}, 32'd1);
    send(8'h07);
    chk("loss_err", {16'd0, err}, 32'd4);
    chk("loss_unlock", {31'd0, locked}, 32'd0);
    chk("loss_lastbad", {24'd0, last_bad}, 32'h07);
    send(8'h08);
    chk("loss_next_err", {16'd0, err}, 32'd4);
    chk("loss_next_pulse", {31'd0, pulse}, 32'd0);
    send(8'h09); send(8'h0A);
    chk("relock_pre", {31'd0, locked}, 32'd0);
    send(8'h0B);
    chk("relock", {31'd0, locked}, 32'd1);
    chk("relock_good", {16'd0, good}, 32'd1);

    // Clear colliding with a strobe
    clr     = 1'b1;
    dv      = 1'b1;
    rx_byte = 8'h33;
    @(posedge clk);
    #1;
    clr = 1'b0;
    dv  = 1'b0;
    chk("clr_good", {16'd0, good}, 32'd0);
    chk("clr_err", {16'd0, err}, 32'd0);
    chk("clr_exp", {24'd0, expct}, 32'h00);
    chk("clr_locked", {31'd0, locked}, 32'd0);
    chk("clr_lastbad", {24'd0, last_bad}, 32'h00);
    send(8'h40); send(8'h41); send(8'h42);
    chk("clr_hunt", {31'd0, locked}, 32'd0);
    send(8'h43);
    chk("clr_relock", {31'd0, locked}, 32'd1);

    // Reset mid-confirm discards progress
    do_clear();
    send(8'h60); send(8'h61); send(8'h62);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    send(8'h63); send(8'h64); send(8'h65);
    chk("mid_rst_nolock", {31'd0, locked}, 32'd0);
    send(8'h66);
    chk("mid_rst_lock", {31'd0, locked}, 32'd1);

    // Saturation on the 4-bit instance
    do_clear();
    send(8'h00); send(8'h01); send(8'h02); send(8'h03);
    chk("sat_lock", {31'd0, s_locked}, 32'd1);
    e = 8'h04;
    for (int i = 0; i < 17; i++) begin
      b = e ^ 8'h80;
      send(b);
      e = b + 8'd1;
      if (i == 14) chk("sat_err15", {28'd0, s_err}, 32'hF);
      send(e);
      e = e + 8'd1;
    end
    chk("sat_err", {28'd0, s_err}, 32'hF);
    chk("sat_good", {28'd0, s_good}, 32'hF);
    chk("sat_locked", {31'd0, s_locked}, 32'd1);
    chk("sat_exp", {24'd0, s_expct}, {24'd0, e});

    // Asynchronous reset between edges
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_locked", {31'd0, s_locked}, 32'd0);
    chk("arst_err", {28'd0, s_err}, 32'd0);
    chk("arst_good", {28'd0, s_good}, 32'd0);
    chk("arst_exp", {24'd0, s_expct}, 32'h00);
    chk("arst_lastbad", {24'd0, s_last_bad}, 32'h00);
    chk("arst_pulse", {31'd0, s_pulse}, 32'd0);
    chk("arst_d_locked", {31'd0, locked}, 32'd0);
    chk("arst_d_good", {16'd0, good}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
